otbn_pq_ntt_sched: RTL and testbench

NTT loop-index scheduler for the OTBN post-quantum extension. It holds the butterfly loop state: half-distance M, span J2, inner index J, pair indices Idx0/Idx1 and Mode. It advances that state once per retired butterfly instruction and flags the points where the decoder must update the twiddle (omega/psi index increment). Its outputs feed the PQ control-SPR read mux and the indirect operand-addressing logic of the PQ ALU.

---
 rtl/otbn_pq_ntt_sched.sv | 175 +++++++++++++++++
 tb/tb_otbn_pq_ntt_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/otbn_pq_ntt_sched.sv
// otbn_pq_ntt_sched: NTT butterfly loop-index scheduler (M, J2, J, Idx0/Idx1, Mode) for the OTBN PQ extension.
// Latency: every command (clr/start/ISPR write/step) is visible on the outputs one cycle later; pulses last one cycle.
// Backpressure: none, a command is accepted every cycle (priority clr > start > ISPR write > step).
// Ports: clk_i/rst_ni (async active-low); start_i + mode_i load stage 0 and enter RUN; step_i advances one
//   butterfly; clr_i aborts to IDLE; ispr_wr_* directly overwrite one field; m_o/j2_o/j_o/idx0_o/idx1_o are
//   the zero-extended indices; busy_o/done_o decode the FSM; twiddle_upd_o/stage_adv_o/err_o are pulses.
// Optional feature: define OTBN_PQ_NTT_SCHED_GS_EN to support Gentleman-Sande (inverse) mode.
module otbn_pq_ntt_sched #(
  parameter int unsigned LogN = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic        step_i,
  input  logic        clr_i,
  input  logic        ispr_wr_en_i,
  input  logic [2:0]  ispr_wr_sel_i,
  input  logic [31:0] ispr_wr_data_i,
  output logic [31:0] m_o,
  output logic [31:0] j2_o,
  output logic [31:0] j_o,
  output logic [31:0] idx0_o,
  output logic [31:0] idx1_o,
  output logic        mode_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        twiddle_upd_o,
  output logic        stage_adv_o,
  output logic        err_o
);

  localparam logic [LogN:0]   NVal  = {1'b1, {LogN{1'b0}}};
  localparam logic [LogN-1:0] HalfN = {1'b1, {(LogN-1){1'b0}}};
  localparam logic [LogN-1:0] MOne  = {{(LogN-1){1'b0}}, 1'b1};
  localparam logic [LogN:0]   J2Gs0 = {{(LogN-1){1'b0}}, 2'b10};

  localparam logic [2:0] SelM    = 3'd0;
  localparam logic [2:0] SelJ2   = 3'd1;
  localparam logic [2:0] SelJ    = 3'd2;
  localparam logic [2:0] SelIdx0 = 3'd3;
  localparam logic [2:0] SelMode = 3'd4;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [LogN-1:0] m_q, j_q;
  logic [LogN:0]   j2_q, idx0_q;
  logic            twiddle_q, stage_q, err_q;
  logic            mode_q;
  logic            start_gs, start_err;

  // Mode register: only exists when GS support is compiled in.
`ifdef OTBN_PQ_NTT_SCHED_GS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= 1'b0;
    end else if (clr_i) begin
      mode_q <= 1'b0;
    end else if (start_i) begin
      mode_q <= mode_i;
    end else if (ispr_wr_en_i && (ispr_wr_sel_i == SelMode)) begin
      mode_q <= ispr_wr_data_i[0];
    end
  end
  assign start_gs  = mode_i;
  assign start_err = 1'b0;
`else
  assign mode_q    = 1'b0;
  assign start_gs  = 1'b0;
  assign start_err = mode_i;
`endif

  // Next-step indices. Compare j+1 against m one bit wider so m = 0 or a
  // saturated j cannot wrap into a false "still inside the group".
  logic [LogN:0]   j_inc, idx0_step, j2_stage;
  logic [LogN-1:0] j_step, m_stage;
  logic            grp_end, stg_end, last_stage;

  assign j_inc     = {1'b0, j_q} + {{LogN{1'b0}}, 1'b1};
  assign grp_end   = ~(j_inc < {1'b0, m_q});
  assign j_step    = grp_end ? {LogN{1'b0}} : j_inc[LogN-1:0];
  assign idx0_step = idx0_q + {{LogN{1'b0}}, 1'b1} + (grp_end ? {1'b0, m_q} : {(LogN+1){1'b0}});
  assign stg_end   = (idx0_step == NVal);

`ifdef OTBN_PQ_NTT_SCHED_GS_EN
  // GS doubles the half-distance each stage; j2 = 4*m_old keeps j2 = 2*m_new.
  assign m_stage    = mode_q ? (m_q << 1) : (m_q >> 1);
  assign j2_stage   = mode_q ? {m_q[LogN-2:0], 2'b00} : {1'b0, m_q};
  assign last_stage = mode_q ? (m_q == HalfN) : (m_q == MOne);
`else
  assign m_stage    = m_q >> 1;
  assign j2_stage   = {1'b0, m_q};
  assign last_stage = (m_q == MOne);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      m_q       <= '0;
      j2_q      <= '0;
      j_q       <= '0;
      idx0_q    <= '0;
      twiddle_q <= 1'b0;
      stage_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      twiddle_q <= 1'b0;
      stage_q   <= 1'b0;
      err_q     <= 1'b0;
      if (clr_i) begin
        state_q <= StIdle;
        m_q     <= '0;
        j2_q    <= '0;
        j_q     <= '0;
        idx0_q  <= '0;
      end else if (start_i) begin
        state_q <= StRun;
        m_q     <= start_gs ? MOne : HalfN;
        j2_q    <= start_gs ? J2Gs0 : NVal;
        j_q     <= '0;
        idx0_q  <= '0;
        err_q   <= start_err;
      end else if (ispr_wr_en_i) begin
        case (ispr_wr_sel_i)
          SelM:    m_q    <= ispr_wr_data_i[LogN-1:0];
          SelJ2:   j2_q   <= ispr_wr_data_i[LogN:0];
          SelJ:    j_q    <= ispr_wr_data_i[LogN-1:0];
          SelIdx0: idx0_q <= ispr_wr_data_i[LogN:0];
          default: ; // Mode lives in its own register; selects 5..7 are ignored
        endcase
      end else if (step_i) begin
        if (state_q != StRun) begin
          err_q <= 1'b1;
        end else begin
          j_q       <= j_step;
          twiddle_q <= grp_end;
          if (stg_end) begin
            idx0_q  <= '0;
            stage_q <= 1'b1;
            // The final stage keeps m/j2 so software can read where it ended.
            if (last_stage) begin
              state_q <= StDone;
            end else begin
              m_q  <= m_stage;
              j2_q <= j2_stage;
            end
          end else begin
            idx0_q <= idx0_step;
          end
        end
      end
    end
  end

  logic [LogN:0] idx1;
  assign idx1 = idx0_q + {1'b0, m_q};

  // Upper write-data bits are deliberately truncated.
  logic unused_wr_data;
  assign unused_wr_data = ^ispr_wr_data_i[31:LogN+1];

  assign m_o           = {{(32-LogN){1'b0}}, m_q};
  assign j_o           = {{(32-LogN){1'b0}}, j_q};
  assign j2_o          = {{(31-LogN){1'b0}}, j2_q};
  assign idx0_o        = {{(31-LogN){1'b0}}, idx0_q};
  assign idx1_o        = {{(31-LogN){1'b0}}, idx1};
  assign mode_o        = mode_q;
  assign busy_o        = (state_q == StRun);
  assign done_o        = (state_q == StDone);
  assign twiddle_upd_o = twiddle_q;
  assign stage_adv_o   = stage_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_otbn_pq_ntt_sched.sv
module tb_otbn_pq_ntt_sched;

  localparam int LOGN = 8;
  localparam int N    = 1 << LOGN;
`ifdef OTBN_PQ_NTT_SCHED_GS_EN
  localparam bit GS_EN = 1'b1;
`else
  localparam bit GS_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0, mode_i = 1'b0, step_i = 1'b0, clr_i = 1'b0;
  logic        ispr_wr_en_i = 1'b0;
  logic [2:0]  ispr_wr_sel_i = 3'd0;
  logic [31:0] ispr_wr_data_i = 32'd0;
  logic [31:0] m_o, j2_o, j_o, idx0_o, idx1_o;
  logic        mode_o, busy_o, done_o, twiddle_upd_o, stage_adv_o, err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  otbn_pq_ntt_sched #(.LogN(LOGN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .step_i(step_i), .clr_i(clr_i), .ispr_wr_en_i(ispr_wr_en_i),
    .ispr_wr_sel_i(ispr_wr_sel_i), .ispr_wr_data_i(ispr_wr_data_i),
    .m_o(m_o), .j2_o(j2_o), .j_o(j_o), .idx0_o(idx0_o), .idx1_o(idx1_o),
    .mode_o(mode_o), .busy_o(busy_o), .done_o(done_o),
    .twiddle_upd_o(twiddle_upd_o), .stage_adv_o(stage_adv_o), .err_o(err_o)
  );

  // Reference schedule: the list of butterflies of a whole transform,
  // enumerated stage by stage and group by group.
  typedef struct {
    int m;
    int j;
    int idx0;
    bit grp_last;
    bit stg_last;
  } bfly_t;
  bfly_t bf[$];
  int    k_pos;

  // Expected architectural state.
  int e_m, e_j2, e_j, e_idx0;
  bit e_busy, e_done, e_mode;

  function automatic void build_schedule(input bit gs);
    bfly_t b;
    int    m;
    bf.delete();
    for (int s = 0; s < LOGN; s++) begin
      m = gs ? (1 << s) : (N >> (s + 1));
      for (int base = 0; base < N; base += 2 * m) begin
        for (int j = 0; j < m; j++) begin
          b.m        = m;
          b.j        = j;
          b.idx0     = base + j;
          b.grp_last = (j == m - 1);
          b.stg_last = (j == m - 1) && (base + 2 * m == N);
          bf.push_back(b);
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input bit tw, input bit st, input bit er);
    chk({tag, " m"},       m_o,           e_m);
    chk({tag, " j2"},      j2_o,          e_j2);
    chk({tag, " j"},       j_o,           e_j);
    chk({tag, " idx0"},    idx0_o,        e_idx0);
    chk({tag, " idx1"},    idx1_o,        e_idx0 + e_m);
    chk({tag, " mode"},    {31'd0, mode_o},        {31'd0, e_mode});
    chk({tag, " busy"},    {31'd0, busy_o},        {31'd0, e_busy});
    chk({tag, " done"},    {31'd0, done_o},        {31'd0, e_done});
    chk({tag, " twiddle"}, {31'd0, twiddle_upd_o}, {31'd0, tw});
    chk({tag, " stage"},   {31'd0, stage_adv_o},   {31'd0, st});
    chk({tag, " err"},     {31'd0, err_o},         {31'd0, er});
  endtask

  task automatic zero_expect();
    e_m = 0; e_j2 = 0; e_j = 0; e_idx0 = 0;
    e_busy = 0; e_done = 0; e_mode = 0;
  endtask

  task automatic do_start(input bit md, input string tag);
    bit gs;
    gs = md && GS_EN;
    start_i = 1'b1;
    mode_i  = md;
    tick();
    start_i = 1'b0;
    mode_i  = 1'b0;
    build_schedule(gs);
    k_pos  = 0;
    e_m    = bf[0].m;
    e_j2   = 2 * e_m;
    e_j    = 0;
    e_idx0 = 0;
    e_busy = 1;
    e_done = 0;
    e_mode = gs;
    chk_state(tag, 1'b0, 1'b0, md && !GS_EN);
  endtask

  // Retire n butterflies, optionally with random idle cycles in between.
  task automatic do_steps(input int n, input bit gaps, input string tag);
    bit tw, st;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        step_i = 1'b0;
        tick();
        chk_state({tag, " idle"}, 1'b0, 1'b0, 1'b0);
      end
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
      tw = bf[k_pos].grp_last;
      st = bf[k_pos].stg_last;
      if (k_pos == bf.size() - 1) begin
        e_j = 0; e_idx0 = 0; e_busy = 0; e_done = 1;
      end else begin
        e_m    = bf[k_pos + 1].m;
        e_j2   = 2 * e_m;
        e_j    = bf[k_pos + 1].j;
        e_idx0 = bf[k_pos + 1].idx0;
      end
      k_pos++;
      chk_state(tag, tw, st, 1'b0);
    end
  endtask

  task automatic ispr_write(input logic [2:0] sel, input logic [31:0] data, input bit with_step);
    ispr_wr_en_i   = 1'b1;
    ispr_wr_sel_i  = sel;
    ispr_wr_data_i = data;
    step_i         = with_step;
    tick();
    ispr_wr_en_i   = 1'b0;
    step_i         = 1'b0;
  endtask

  task automatic do_clr(input string tag);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    zero_expect();
    chk_state(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int          r;
    logic [31:0] d;

    // Reset
    zero_expect();
    tick();
    chk_state("in_reset", 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    tick();
    chk_state("after_reset", 1'b0, 1'b0, 1'b0);

    // Step in IDLE is illegal and ignored
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    chk_state("step_idle", 1'b0, 1'b0, 1'b1);
    tick();
    chk_state("err_one_cycle", 1'b0, 1'b0, 1'b0);

    // Full CT transform, back-to-back steps
    do_start(1'b0, "ct_start");
    do_steps(1, 1'b0, "ct_first");
    do_steps(N * LOGN / 2 - 1, 1'b0, "ct_run");
    chk("ct_total_steps", k_pos, 1024);

    // Extra step in DONE
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    chk_state("step_done", 1'b0, 1'b0, 1'b1);
    tick();
    chk_state("done_hold", 1'b0, 1'b0, 1'b0);

    // DONE -> RUN, random partial run with idle gaps, then ISPR writes
    do_start(1'b0, "ct_restart");
    r = $urandom_range(1, 300);
    do_steps(r, 1'b1, "ct_partial");
    d = 32'd40 | ($urandom() << (LOGN + 1));
    ispr_write(3'd3, d, 1'b1);
    e_idx0 = 40;
    chk_state("wr_idx0_with_step", 1'b0, 1'b0, 1'b0);
    d = $urandom();
    ispr_write(3'd0, d, 1'b0);
    e_m = d & (N - 1);
    chk_state("wr_m", 1'b0, 1'b0, 1'b0);
    d = $urandom();
    ispr_write(3'd2, d, 1'b0);
    e_j = d & (N - 1);
    chk_state("wr_j", 1'b0, 1'b0, 1'b0);
    d = $urandom();
    ispr_write(3'd1, d, 1'b0);
    e_j2 = d & (2 * N - 1);
    chk_state("wr_j2", 1'b0, 1'b0, 1'b0);
    ispr_write(3'($urandom_range(5, 7)), $urandom(), 1'b0);
    chk_state("wr_ignored_sel", 1'b0, 1'b0, 1'b0);
    ispr_write(3'd4, 32'd1, 1'b0);
    e_mode = GS_EN;
    chk_state("wr_mode", 1'b0, 1'b0, 1'b0);
    do_clr("clr_mid_run");

    // Start with mode_i = 1
    do_start(1'b1, "gs_start");
    do_steps(1, 1'b0, "gs_first");
    if (GS_EN) begin
      chk("gs_idx0_after_1", idx0_o, 2);
      chk("gs_idx1_after_1", idx1_o, 3);
    end else begin
      chk("ct_fallback_m", m_o, 128);
    end
    do_steps(N * LOGN / 2 - 1, 1'b1, "mode1_run");

    // Priority: clr beats start
    clr_i = 1'b1; start_i = 1'b1;
    tick();
    clr_i = 1'b0; start_i = 1'b0;
    zero_expect();
    chk_state("clr_over_start", 1'b0, 1'b0, 1'b0);

    // ISPR write beats step in IDLE: no error
    d = $urandom_range(1, N - 1);
    ispr_write(3'd2, d, 1'b1);
    e_j = d;
    chk_state("wr_over_step_idle", 1'b0, 1'b0, 1'b0);

    // Start beats step
    start_i = 1'b1; step_i = 1'b1;
    tick();
    start_i = 1'b0; step_i = 1'b0;
    build_schedule(1'b0);
    k_pos = 0;
    e_m = N / 2; e_j2 = N; e_j = 0; e_idx0 = 0; e_busy = 1; e_done = 0; e_mode = 0;
    chk_state("start_over_step", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run
    do_steps($urandom_range(1, 200), 1'b1, "pre_reset");
    rst_ni = 1'b0;
    #1;
    zero_expect();
    chk_state("async_reset", 1'b0, 1'b0, 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk_state("post_reset", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
